// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, parity helper
// and the cycle-count constants derived from clock frequency and timing targets.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_DATA    = 3'd3,
    ST_WAITREL = 3'd4
  } ps2_state_e;

  localparam int unsigned PS2_CLOCK_KHZ  = 28000;
  localparam int unsigned PS2_INHIBIT_US = 100;
  localparam int unsigned PS2_TIMEOUT_MS = 15;
  localparam int unsigned PS2_BIT_W      = 4;

  function automatic int unsigned ps2_inhibit_cycles(input int unsigned khz, input int unsigned us);
    return khz * us / 1000;
  endfunction

  function automatic int unsigned ps2_timeout_cycles(input int unsigned khz, input int unsigned ms);
    return khz * ms;
  endfunction

  // One down-counter serves both the inhibit pulse and the timeout.
  function automatic int ps2_cnt_width(input int unsigned a, input int unsigned b);
    return (a > b) ? $clog2(a + 1) : $clog2(b + 1);
  endfunction

  localparam int unsigned PS2_INHIBIT_CYCLES = ps2_inhibit_cycles(PS2_CLOCK_KHZ, PS2_INHIBIT_US);
  localparam int unsigned PS2_TIMEOUT_CYCLES = ps2_timeout_cycles(PS2_CLOCK_KHZ, PS2_TIMEOUT_MS);
  localparam int          PS2_CNT_W          = ps2_cnt_width(PS2_INHIBIT_CYCLES, PS2_TIMEOUT_CYCLES);

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic ps2_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data pins and flags PS/2 clock falling edges.
// Optional glitch filter on the clock line when PS2TX_FILTER_EN is defined.
module ps2_line_sync (
  input  logic clock,
  input  logic nreset,
  input  logic ck_in,
  input  logic dq_in,
  output logic ck_sync,
  output logic dq_sync,
  output logic ck_fall
);

  logic [1:0] ck_ff;
  logic [1:0] dq_ff;
  logic       ck_clean;
  logic       ck_prev;

  // Idle bus level is high, so the synchronizers reset to 1.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ck_ff <= 2'b11;
      dq_ff <= 2'b11;
    end else begin
      ck_ff <= {ck_ff[0], ck_in};
      dq_ff <= {dq_ff[0], dq_in};
    end
  end

`ifdef PS2TX_FILTER_EN
  logic [2:0] flt_cnt;
  logic       ck_flt;

  // Output follows the input only after 8 consecutive differing samples.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      flt_cnt <= 3'd0;
      ck_flt  <= 1'b1;
    end else if (ck_ff[1] == ck_flt) begin
      flt_cnt <= 3'd0;
    end else if (flt_cnt == 3'd7) begin
      flt_cnt <= 3'd0;
      ck_flt  <= ck_ff[1];
    end else begin
      flt_cnt <= flt_cnt + 3'd1;
    end
  end

  assign ck_clean = ck_flt;
`else
  assign ck_clean = ck_ff[1];
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ck_prev <= 1'b1;
    end else begin
      ck_prev <= ck_clean;
    end
  end

  assign ck_sync = ck_clean;
  assign dq_sync = dq_ff[1];
  assign ck_fall = ck_prev & ~ck_clean;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check
// and timeout. Define PS2TX_FILTER_EN to add the clock-line stability filter.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLOCK_KHZ  = PS2_CLOCK_KHZ,
  parameter int unsigned INHIBIT_US = PS2_INHIBIT_US,
  parameter int unsigned TIMEOUT_MS = PS2_TIMEOUT_MS
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2CkIn,
  input  logic       ps2DqIn,
  output logic       ps2CkOut,
  output logic       ps2DqOut,
  output logic [2:0] state_dbg
);

  localparam int unsigned INHIBIT_CYCLES = ps2_inhibit_cycles(CLOCK_KHZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYCLES = ps2_timeout_cycles(CLOCK_KHZ, TIMEOUT_MS);
  localparam int          CNT_W          = ps2_cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic ck_sync, dq_sync, ck_fall;

  ps2_line_sync u_line_sync (
    .clock   (clock),
    .nreset  (nreset),
    .ck_in   (ps2CkIn),
    .dq_in   (ps2DqIn),
    .ck_sync (ck_sync),
    .dq_sync (dq_sync),
    .ck_fall (ck_fall)
  );

  ps2_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PS2_BIT_W-1:0] n_q, n_d;
  logic [9:0]           shift_q, shift_d;
  logic                 ck_q, ck_d;
  logic                 dq_q, dq_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      shift_q <= '1;
      ck_q    <= 1'b1;
      dq_q    <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      ck_q    <= ck_d;
      dq_q    <= dq_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    shift_d = shift_q;
    ck_d    = ck_q;
    dq_d    = dq_q;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        // The done cycle is already IDLE; a start landing on it is dropped.
        if (start && !done_q) begin
          shift_d = {1'b1, ps2_parity(data), data};
          error_d = 1'b0;
          cnt_d   = INHIBIT_LOAD;
          n_d     = '0;
          ck_d    = 1'b0;
          dq_d    = (INHIBIT_LOAD != '0);
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          ck_d    = 1'b1;
          cnt_d   = TIMEOUT_LOAD;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Start bit goes low in the final inhibit cycle.
          if (cnt_q == CNT_W'(1)) dq_d = 1'b0;
        end
      end
      ST_REQ, ST_DATA, ST_WAITREL: begin
        if (cnt_q == '0) begin
          dq_d    = 1'b1;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (state_q == ST_WAITREL) begin
            if (ck_sync && dq_sync) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (ck_fall) begin
            n_d = n_q + 1'b1;
            // Fall 11 is the device's ACK slot; earlier falls shift out data, parity, stop.
            if (n_q == PS2_BIT_W'(10)) begin
              error_d = dq_sync;
              state_d = ST_WAITREL;
            end else begin
              dq_d    = shift_q[0];
              shift_d = {1'b1, shift_q[9:1]};
              state_d = ST_DATA;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign ps2CkOut  = ck_q;
  assign ps2DqOut  = dq_q;
  assign state_dbg = state_q;

endmodule
